rf_param: RTL and testbench
===========================

# rf_param

Parametrised register file for the lab datapath: DEPTH = 2^ADDR_W words of DATA_W bits, one write port and two independent read ports (X and Y), all in the `fpga_clk` domain. Writes are launched by a slow external strobe (switch or button) that the block synchronises and edge-detects, so every press commits exactly one write. A built-in scan port cycles through all words for the seven-segment display driver. Reads are registered and include write-through bypass.

## Interface
Parameters:
- `DATA_W`, default 4: word width.
- `ADDR_W`, default 2: address width; DEPTH = 2^ADDR_W.
- `SCAN_DIV`, default 1_000_000: `fpga_clk` cycles per scan step; must be ≥ 1.

Ports:
- `fpga_clk`  in  1  system clock; one clock domain; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_req`  in  1  raw write strobe, asynchronous to `fpga_clk`; its rising edge requests one write.
- `wr_en`  in  1  write enable, sampled on the same cycle as the detected strobe edge.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_x`, `rd_y`  in  1  read selects for the legacy `dout` mux.
- `addr_x`, `addr_y`  in  ADDR_W  read addresses.
- `dout_x`, `dout_y`  out  DATA_W  registered read data for port X and port Y.
- `dout`  out  DATA_W  registered: `dout_x` if only `rd_x` is high, `dout_y` if only `rd_y` is high, 0 if both or neither is high.
- `wr_done`  out  1  one-cycle pulse after each committed write.
- `wr_count`  out  8  count of committed writes; wraps from 255 to 0.
- `scan_addr`  out  ADDR_W  current scan index.
- `scan_data`  out  DATA_W  registered word at `scan_addr`.

## Operation
- Strobe path: `wr_req` passes through sync flops s1→s2→s3. The internal pulse `wp = s2 & ~s3`.
- Commit: if `wp & wr_en`, then `mem[wr_addr] <= wr_data`, `wr_count` increments, and `wr_done` is set for the next cycle. If `wp` fires with `wr_en` low, nothing happens: no write, no count, no `wr_done`.
- Read: every cycle, `dout_x <= mem[addr_x]` and `dout_y <= mem[addr_y]`.
- Bypass: if a write commits on the same edge and `wr_addr == addr_x` (or `addr_y`), that output loads `wr_data`, not the old word.
- `dout` is derived from the same next-state values, so it is consistent with `dout_x`/`dout_y` on every cycle.
- Scan: a prescaler counts 0..SCAN_DIV-1. On terminal count it returns to 0 and `scan_addr` increments, wrapping DEPTH-1→0.
  - SCAN_DIV = 1: `scan_addr` advances every cycle.
  - `scan_data <= mem[scan_addr]` every cycle, with bypass on a matching write.
- Reset (async, any time, including mid-strobe):
  - all `mem` words = 0; `dout_x`, `dout_y`, `dout`, `scan_data` = 0.
  - `wr_done` = 0, `wr_count` = 0, `scan_addr` = 0, prescaler = 0.
  - s1, s2, s3 = 1. A `wr_req` held high through reset release therefore produces no write. The next genuine low→high transition does produce one.
  - A pending strobe in the sync chain is discarded.

## Timing
- `wr_req` rises before edge E1 (setup met):
  - E1: s1 = 1.
  - E2: s2 = 1, and `wp` is high during E2→E3.
  - E3: memory written, `wr_count` updated, `dout_*` show bypassed data, `wr_done` high E3→E4.
- Write-to-read latency for the same address: 0 extra cycles, via bypass at E3.
- Read latency with no write: 1 cycle from address change to `dout_*`.
- Repeat strobes need `wr_req` low for ≥ 2 cycles between them. Holding `wr_req` high produces exactly one write.
- Output behaviour:
  - `wr_done` is never high for two consecutive cycles.
  - `wr_count` and `mem` change on the same edge.
  - `scan_data` lags `scan_addr` by 1 cycle.

## Test plan
- Reset then idle: all outputs 0. With DATA_W = 4 and ADDR_W = 2, read all four addresses on X and Y → 0.
- Write 0xA to address 2: pulse `wr_req` with `wr_en` = 1 and `addr_x` = 2 → `dout_x` = 0xA from E3, `wr_done` high for exactly one cycle (E3→E4), `wr_count` = 1.
- Strobe with `wr_en` = 0 → memory unchanged, `wr_count` unchanged, no `wr_done`. Hold `wr_req` high for 50 cycles with `wr_en` = 1 → exactly one write, `wr_count` +1.
- Legacy mux: write 0x3 to address 1 and 0xC to address 2; set `addr_x` = 1, `addr_y` = 2.
  - `rd_x` = 1, `rd_y` = 0 → `dout` = 0x3.
  - `rd_x` = 0, `rd_y` = 1 → `dout` = 0xC.
  - both high → 0; both low → 0.
- Scan with SCAN_DIV = 3 after writing 1, 2, 3, 4 to addresses 0..3 → `scan_addr` steps every 3 cycles through 0,1,2,3,0 and `scan_data` follows with 1-cycle lag.
- Reset edge cases:
  - Assert `rst` between E1 and E3 of a strobe → no write, `wr_count` = 0.
  - Release `rst` with `wr_req` high → no write.
  - Then drop `wr_req` and raise it again → one write.
  - Perform 256 writes → `wr_count` wraps to 0.

Source files
------------

// File: rtl/rf_param.sv
// rf_param: parametrised register file with one strobe-driven write port,
// two registered read ports with write-through bypass, a legacy output mux
// and a free-running scan port for a seven-segment display driver.
module rf_param #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned SCAN_DIV = 1_000_000
) (
    input  logic              fpga_clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_x,
    input  logic              rd_y,
    input  logic [ADDR_W-1:0] addr_x,
    input  logic [ADDR_W-1:0] addr_y,
    output logic [DATA_W-1:0] dout_x,
    output logic [DATA_W-1:0] dout_y,
    output logic [DATA_W-1:0] dout,
    output logic              wr_done,
    output logic [7:0]        wr_count,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = 8;

    // Strobe synchroniser; reset to ones so a strobe held through reset is ignored
    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Storage and registered outputs
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] dout_x_q, dout_x_d;
    logic [DATA_W-1:0] dout_y_q, dout_y_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              wr_done_q, wr_done_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    // Scan prescaler and pointer
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic [DATA_W-1:0] scan_data_q, scan_data_d;

    // Combinational strobe edge and commit qualifier
    logic wp_c;
    logic commit_c;
    logic ps_tc_c;

    // Edge detect on the synchronised strobe; commit only when enabled
    always_comb begin
        s1_d     = wr_req;
        s2_d     = s1_q;
        s3_d     = s2_q;
        wp_c     = s2_q & ~s3_q;
        commit_c = wp_c & wr_en;
    end

    // Next memory image and write bookkeeping
    always_comb begin
        mem_d      = mem_q;
        wr_count_d = wr_count_q;
        wr_done_d  = 1'b0;
        if (commit_c) begin
            mem_d[wr_addr] = wr_data;
            wr_count_d     = wr_count_q + CNT_W'(1);
            wr_done_d      = 1'b1;
        end
    end

    // Read ports look at the next memory image, which gives write-through bypass
    always_comb begin
        dout_x_d = mem_d[addr_x];
        dout_y_d = mem_d[addr_y];
        dout_d   = '0;
        if (rd_x && !rd_y) begin
            dout_d = dout_x_d;
        end else if (!rd_x && rd_y) begin
            dout_d = dout_y_d;
        end
    end

    // Scan prescaler steps the pointer once every SCAN_DIV cycles
    always_comb begin
        ps_tc_c     = (ps_q == PS_W'(SCAN_DIV - 1));
        ps_d        = ps_q + PS_W'(1);
        scan_addr_d = scan_addr_q;
        if (ps_tc_c) begin
            ps_d        = '0;
            scan_addr_d = scan_addr_q + ADDR_W'(1);
        end
        scan_data_d = mem_d[scan_addr_q];
    end

    // Synchroniser flops
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Memory array
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read, status and scan registers
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            dout_x_q    <= '0;
            dout_y_q    <= '0;
            dout_q      <= '0;
            wr_done_q   <= 1'b0;
            wr_count_q  <= '0;
            ps_q        <= '0;
            scan_addr_q <= '0;
            scan_data_q <= '0;
        end else begin
            dout_x_q    <= dout_x_d;
            dout_y_q    <= dout_y_d;
            dout_q      <= dout_d;
            wr_done_q   <= wr_done_d;
            wr_count_q  <= wr_count_d;
            ps_q        <= ps_d;
            scan_addr_q <= scan_addr_d;
            scan_data_q <= scan_data_d;
        end
    end

    // Output mapping
    assign dout_x    = dout_x_q;
    assign dout_y    = dout_y_q;
    assign dout      = dout_q;
    assign wr_done   = wr_done_q;
    assign wr_count  = wr_count_q;
    assign scan_addr = scan_addr_q;
    assign scan_data = scan_data_q;

endmodule

// File: tb/tb_rf_param.sv
// Directed self-checking bench for rf_param (DATA_W=4, ADDR_W=2, SCAN_DIV=3).
module tb_rf_param;

    logic       fpga_clk = 1'b0;
    logic       rst;
    logic       wr_req;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       rd_x, rd_y;
    logic [1:0] addr_x, addr_y;
    logic [3:0] dout_x, dout_y, dout;
    logic       wr_done;
    logic [7:0] wr_count;
    logic [1:0] scan_addr;
    logic [3:0] scan_data;

    int vectors = 0;
    int miscompares = 0;

    rf_param #(.DATA_W(4), .ADDR_W(2), .SCAN_DIV(3)) dut (
        .fpga_clk (fpga_clk),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .addr_x   (addr_x),
        .addr_y   (addr_y),
        .dout_x   (dout_x),
        .dout_y   (dout_y),
        .dout     (dout),
        .wr_done  (wr_done),
        .wr_count (wr_count),
        .scan_addr(scan_addr),
        .scan_data(scan_data)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge fpga_clk);
        #1;
    endtask

    // One strobe: high for 3 cycles, low for 2; returns number of wr_done cycles seen
    task automatic do_write(input logic [1:0] a, input logic [3:0] d, input logic en,
                            output int done);
        done    = 0;
        wr_addr = a;
        wr_data = d;
        wr_en   = en;
        wr_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (wr_done) done++;
        end
        wr_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (wr_done) done++;
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int         done;
        int         cnt;
        int         waited;
        logic [1:0] prev;
        logic [1:0] exp_addr;
        logic [1:0] exp_prev;
        logic [3:0] model [4];

        rst = 1'b1; wr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_x = 1'b0; rd_y = 1'b0; addr_x = '0; addr_y = '0;

        // Reset state
        step(); step();
        chk("rst_dout_x", 32'(dout_x), 32'h0);
        chk("rst_dout_y", 32'(dout_y), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_wr_done", 32'(wr_done), 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        chk("rst_scan_addr", 32'(scan_addr), 32'h0);
        chk("rst_scan_data", 32'(scan_data), 32'h0);
        rst = 1'b0;
        step(); step();

        // All words read zero on both ports
        for (int a = 0; a < 4; a++) begin
            addr_x = 2'(a);
            addr_y = 2'(3 - a);
            step();
            chk("idle_read_x", 32'(dout_x), 32'h0);
            chk("idle_read_y", 32'(dout_y), 32'h0);
        end

        // Write 0xA to address 2, cycle by cycle
        addr_x = 2'd2; wr_addr = 2'd2; wr_data = 4'hA; wr_en = 1'b1; wr_req = 1'b1;
        step();
        chk("wr_e1_done", 32'(wr_done), 32'h0);
        step();
        chk("wr_e2_done", 32'(wr_done), 32'h0);
        chk("wr_e2_dout_x", 32'(dout_x), 32'h0);
        step();
        chk("wr_e3_done", 32'(wr_done), 32'h1);
        chk("wr_e3_dout_x", 32'(dout_x), 32'hA);
        chk("wr_e3_count", 32'(wr_count), 32'h1);
        wr_req = 1'b0;
        step();
        chk("wr_e4_done", 32'(wr_done), 32'h0);
        wr_en = 1'b0;
        step();

        // Strobe with wr_en low does nothing
        do_write(2'd2, 4'h5, 1'b0, done);
        chk("noen_done", 32'(done), 32'h0);
        chk("noen_count", 32'(wr_count), 32'h1);
        chk("noen_dout_x", 32'(dout_x), 32'hA);

        // Held strobe gives exactly one write
        addr_y = 2'd3; wr_addr = 2'd3; wr_data = 4'h7; wr_en = 1'b1; wr_req = 1'b1;
        done = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (wr_done) done++;
        end
        wr_req = 1'b0; wr_en = 1'b0;
        step(); step();
        chk("hold_done", 32'(done), 32'h1);
        chk("hold_count", 32'(wr_count), 32'h2);
        chk("hold_dout_y", 32'(dout_y), 32'h7);

        // Legacy dout mux
        do_write(2'd1, 4'h3, 1'b1, done);
        do_write(2'd2, 4'hC, 1'b1, done);
        addr_x = 2'd1; addr_y = 2'd2;
        rd_x = 1'b1; rd_y = 1'b0; step();
        chk("mux_x_dout_x", 32'(dout_x), 32'h3);
        chk("mux_x_dout_y", 32'(dout_y), 32'hC);
        chk("mux_x", 32'(dout), 32'h3);
        rd_x = 1'b0; rd_y = 1'b1; step();
        chk("mux_y", 32'(dout), 32'hC);
        rd_x = 1'b1; rd_y = 1'b1; step();
        chk("mux_both", 32'(dout), 32'h0);
        rd_x = 1'b0; rd_y = 1'b0; step();
        chk("mux_none", 32'(dout), 32'h0);
        chk("mux_count", 32'(wr_count), 32'h4);

        // Scan: words 1,2,3,4 at addresses 0..3
        model[0] = 4'h1; model[1] = 4'h2; model[2] = 4'h3; model[3] = 4'h4;
        for (int a = 0; a < 4; a++) begin
            do_write(2'(a), model[a], 1'b1, done);
        end
        chk("scan_count", 32'(wr_count), 32'h8);
        prev = scan_addr;
        waited = 0;
        while (scan_addr == prev && waited < 10) begin
            step();
            waited++;
        end
        chk("scan_step_seen", 32'(scan_addr != prev), 32'h1);
        chk("scan_first_addr", 32'(scan_addr), 32'(prev + 2'd1));
        chk("scan_first_data", 32'(scan_data), 32'(model[prev]));
        exp_addr = prev + 2'd1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            cnt++;
            exp_prev = exp_addr;
            if (cnt == 3) begin
                exp_addr = exp_addr + 2'd1;
                cnt = 0;
            end
            chk("scan_addr", 32'(scan_addr), 32'(exp_addr));
            chk("scan_data", 32'(scan_data), 32'(model[exp_prev]));
        end

        // Reset between E2 and E3 of a strobe discards it
        addr_x = 2'd0; wr_addr = 2'd0; wr_data = 4'hF; wr_en = 1'b1; wr_req = 1'b1;
        step(); step();
        rst = 1'b1;
        #1;
        chk("midrst_async_count", 32'(wr_count), 32'h0);
        chk("midrst_async_dout_x", 32'(dout_x), 32'h0);
        wr_req = 1'b0;
        step(); step();
        rst = 1'b0;
        done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wr_done) done++;
        end
        wr_en = 1'b0;
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_count", 32'(wr_count), 32'h0);
        chk("midrst_mem0", 32'(dout_x), 32'h0);

        // Strobe held high through reset release gives no write
        rst = 1'b1; wr_req = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h9;
        step(); step();
        rst = 1'b0;
        done = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wr_done) done++;
        end
        chk("relhi_done", 32'(done), 32'h0);
        chk("relhi_count", 32'(wr_count), 32'h0);
        wr_req = 1'b0;
        step(); step();
        addr_x = 2'd1;
        do_write(2'd1, 4'h9, 1'b1, done);
        chk("relhi_next_done", 32'(done), 32'h1);
        chk("relhi_next_count", 32'(wr_count), 32'h1);
        chk("relhi_next_data", 32'(dout_x), 32'h9);

        // Count wrap after 256 writes
        for (int i = 0; i < 254; i++) begin
            do_write(2'(i), 4'(i), 1'b1, done);
        end
        chk("wrap_255", 32'(wr_count), 32'hFF);
        do_write(2'd0, 4'h6, 1'b1, done);
        chk("wrap_0", 32'(wr_count), 32'h0);
        chk("wrap_done", 32'(done), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
